// File: rtl/fifo_s16_s2_pkg.sv
// fifo_s16_s2_pkg: shared widths and dibit extraction for the 16-to-2 unpacking FIFO (FIFO_S16_S2_MSB_FIRST_EN selects MSB-first order)
package fifo_s16_s2_pkg;
   localparam int WORD_W        = 16;
   localparam int SYM_W         = 2;
   localparam int SYMS_PER_WORD = 8;
   localparam int SYM_IDX_W     = 3;
   function automatic logic [SYM_W-1:0] sym_of(input logic [WORD_W-1:0] w, input logic [SYM_IDX_W-1:0] n);
`ifdef FIFO_S16_S2_MSB_FIRST_EN
      return w[{~n, 1'b0} +: SYM_W];
`else
      return w[{n, 1'b0} +: SYM_W];
`endif
   endfunction
endpackage

// File: rtl/fifo_s16_s2_ram.sv
// fifo_s16_s2_ram: simple dual-port RAM, one write port and one registered read port
module fifo_s16_s2_ram #(
   parameter int AW = 8,
   parameter int W  = 16
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);
   logic [W-1:0] r_mem [2**AW];
   logic [W-1:0] r_q;
   assign o_rdata = r_q;
   // write port and registered read port; contents are never cleared
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_q <= r_mem[i_raddr];
   end
endmodule

// File: rtl/fifo_s16_s2_unpack.sv
// fifo_s16_s2_unpack: 16-bit word FIFO read out as dibits (FIFO_S16_S2_MSB_FIRST_EN selects MSB-first order)
module fifo_s16_s2_unpack
   import fifo_s16_s2_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WORD_W-1:0]     WR_DATA,
   input  logic                  WR_VALID,
   output logic                  WR_READY,
   output logic [SYM_W-1:0]      RD_DATA,
   output logic                  RD_VALID,
   input  logic                  RD_READY,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic                  FULL,
   output logic                  EMPTY
);
   localparam int AW = DEPTH_LOG2;
   localparam int LW = DEPTH_LOG2 + 1;
   localparam logic [LW-1:0] CAP = LW'(2**DEPTH_LOG2);
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [LW-1:0]        r_level, w_level_n;
   logic [WORD_W-1:0]    r_cur, r_pf, w_cur_n, w_pf_n, w_ram_q;
   logic                 r_cur_v, r_pf_v, r_inflight, w_cur_v_n, w_pf_v_n;
   logic [SYM_IDX_W-1:0] r_idx, w_idx_n;
   logic [SYM_W-1:0]     r_rd_data;
   logic                 r_full, r_empty;
   logic                 w_wr, w_fire, w_last, w_cur_free, w_fetch;
   logic [1:0]           w_occ;
   assign WR_READY = !r_full;
   assign RD_VALID = r_cur_v;
   assign RD_DATA  = r_rd_data;
   assign LEVEL    = r_level;
   assign FULL     = r_full;
   assign EMPTY    = r_empty;
   assign w_wr       = WR_VALID && !r_full;
   assign w_fire     = r_cur_v && RD_READY;
   assign w_last     = w_fire && (r_idx == SYM_IDX_W'(SYMS_PER_WORD - 1));
   assign w_cur_free = !r_cur_v || w_last;
   // an in-flight RAM read already owns an output slot, so it counts toward the two-word stage
   assign w_occ      = 2'(r_cur_v) + 2'(r_pf_v) + 2'(r_inflight) - 2'(w_last);
   assign w_fetch    = (r_level != '0) && (w_occ < 2'd2);
   assign w_level_n  = r_level + LW'(w_wr) - LW'(w_fetch);
   fifo_s16_s2_ram #(.AW(AW), .W(WORD_W)) u_ram (
      .i_clk   (CLK),
      .i_we    (w_wr && !RST),
      .i_waddr (r_wptr),
      .i_wdata (WR_DATA),
      .i_re    (w_fetch && !RST),
      .i_raddr (r_rptr),
      .o_rdata (w_ram_q)
   );
   // output stage: refill the current word from prefetch or the arriving RAM word, otherwise park arrivals in prefetch
   always_comb begin
      w_cur_n   = r_cur;
      w_cur_v_n = r_cur_v;
      w_pf_n    = r_pf;
      w_pf_v_n  = r_pf_v;
      w_idx_n   = r_idx + SYM_IDX_W'(w_fire);
      if (w_cur_free) begin
         w_idx_n   = '0;
         w_cur_n   = r_pf_v ? r_pf : w_ram_q;
         w_cur_v_n = r_pf_v || r_inflight;
         w_pf_n    = w_ram_q;
         w_pf_v_n  = r_pf_v && r_inflight;
      end else if (r_inflight) begin
         w_pf_n   = w_ram_q;
         w_pf_v_n = 1'b1;
      end
   end
   // control state: pointers, level, output-stage valids and registered flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_idx      <= '0;
         r_cur_v    <= 1'b0;
         r_pf_v     <= 1'b0;
         r_inflight <= 1'b0;
         r_rd_data  <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
      end else begin
         r_wptr     <= r_wptr + AW'(w_wr);
         r_rptr     <= r_rptr + AW'(w_fetch);
         r_level    <= w_level_n;
         r_idx      <= w_idx_n;
         r_cur_v    <= w_cur_v_n;
         r_pf_v     <= w_pf_v_n;
         r_inflight <= w_fetch;
         r_rd_data  <= w_cur_v_n ? sym_of(w_cur_n, w_idx_n) : '0;
         r_full     <= w_level_n == CAP;
         r_empty    <= (w_level_n == '0) && !w_cur_v_n && !w_pf_v_n && !w_fetch;
      end
   end
   // word registers carry no reset; their valid bits qualify them
   always_ff @(posedge CLK) begin
      r_cur <= w_cur_n;
      r_pf  <= w_pf_n;
   end
endmodule

// File: tb/tb_fifo_s16_s2_unpack.sv
// tb_fifo_s16_s2_unpack: scoreboard bench for the dibit unpacking FIFO (honours FIFO_S16_S2_MSB_FIRST_EN)
module tb_fifo_s16_s2_unpack;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] WR_DATA = '0;
   logic        WR_VALID = 1'b0;
   logic        WR_READY;
   logic [1:0]  RD_DATA;
   logic        RD_VALID;
   logic        RD_READY = 1'b0;
   logic [8:0]  LEVEL;
   logic        FULL, EMPTY;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [1:0]  sb [$];
   logic        prev_stall = 1'b0;
   logic [1:0]  prev_data = '0;

   fifo_s16_s2_unpack #(.DEPTH_LOG2(8)) dut (
      .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
      .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_sym(input logic [15:0] w, input int n);
      logic [15:0] s;
`ifdef FIFO_S16_S2_MSB_FIRST_EN
      s = w >> (14 - 2 * n);
`else
      s = w >> (2 * n);
`endif
      return s[1:0];
   endfunction

   task automatic push_word(input logic [15:0] w, input int cnt);
      for (int n = 0; n < cnt; n++) sb.push_back(exp_sym(w, n));
   endtask

   task automatic sync();
      @(posedge CLK);
      #1;
   endtask

   // called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
   task automatic write_word(input logic [15:0] w, input bit push);
      int t = 0;
      WR_DATA  = w;
      WR_VALID = 1'b1;
      @(negedge CLK);
      while (!WR_READY && t < 5000) begin
         @(negedge CLK);
         t++;
      end
      if (!WR_READY) chk("write_timeout", WR_READY, 1);
      @(posedge CLK);
      #1;
      WR_VALID = 1'b0;
      if (push) push_word(w, 8);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(negedge CLK);
         t++;
      end
      chk("drain_left", sb.size(), 0);
      repeat (2) @(negedge CLK);
      chk("drained_rd_valid", RD_VALID, 0);
      chk("drained_empty", EMPTY, 1);
      chk("drained_level", LEVEL, 0);
   endtask

   // monitor: consumes scoreboard entries on accepted dibits and checks stall stability
   always @(negedge CLK) begin
      if (RST) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", RD_VALID, 1);
            chk("hold_data", RD_DATA, prev_data);
         end
         if (RD_VALID && RD_READY) begin
            if (sb.size() == 0) chk("unexpected_dibit", RD_VALID, 0);
            else chk("dibit", RD_DATA, sb.pop_front());
         end
         prev_stall = RD_VALID && !RD_READY;
         prev_data  = RD_DATA;
      end
   end

   initial begin
      int t;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_rd_valid", RD_VALID, 0);
      chk("rst_empty", EMPTY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_wr_ready", WR_READY, 1);
      chk("rst_level", LEVEL, 0);
      chk("rst_rd_data", RD_DATA, 0);

      sync();
      RD_READY = 1'b1;
      write_word(16'hE4E4, 1);
      @(negedge CLK);
      chk("lat_level", LEVEL, 1);
      chk("lat_empty", EMPTY, 0);
      @(negedge CLK);
      chk("lat_t1_valid", RD_VALID, 0);
      @(negedge CLK);
      chk("lat_t2_valid", RD_VALID, 1);
      wait_drain();

      sync();
      write_word(16'h0000, 1);
      write_word(16'hFFFF, 1);
      write_word(16'h5555, 1);
      t = 0;
      while (!RD_VALID && t < 20) begin
         @(negedge CLK);
         t++;
      end
      while (sb.size() > 0 && t < 80) begin
         chk("stream_gap", RD_VALID, 1);
         @(negedge CLK);
         t++;
      end
      wait_drain();

      sync();
      RD_READY = 1'b0;
      for (int i = 0; i < 258; i++) write_word(16'(i), 1);
      @(negedge CLK);
      chk("full_level", LEVEL, 256);
      chk("full_flag", FULL, 1);
      chk("full_wr_ready", WR_READY, 0);
      chk("full_empty", EMPTY, 0);
      sync();
      WR_DATA  = 16'hDEAD;
      WR_VALID = 1'b1;
      repeat (3) @(posedge CLK);
      #1 WR_VALID = 1'b0;
      @(negedge CLK);
      chk("full_ignored_level", LEVEL, 256);
      chk("full_ignored_flag", FULL, 1);
      sync();
      RD_READY = 1'b1;
      wait_drain();

      sync();
      RD_READY = 1'b0;
      write_word(16'h9C63, 1);
      write_word(16'h36C9, 1);
      t = 0;
      while (sb.size() > 0 && t < 200) begin
         sync();
         RD_READY = ~RD_READY;
         t++;
      end
      RD_READY = 1'b1;
      wait_drain();

      sync();
      RD_READY = 1'b0;
      write_word(16'hABCD, 0);
      for (int i = 0; i < 5; i++) write_word(16'h1000 + 16'(i), 0);
      repeat (4) @(posedge CLK);
      #1;
      push_word(16'hABCD, 3);
      RD_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RD_READY = 1'b0;
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("midrst_empty", EMPTY, 1);
      chk("midrst_level", LEVEL, 0);
      chk("midrst_rd_valid", RD_VALID, 0);
      chk("midrst_full", FULL, 0);
      chk("midrst_consumed", sb.size(), 0);
      sync();
      RD_READY = 1'b1;
      write_word(16'h1B1B, 1);
      wait_drain();
      repeat (20) @(negedge CLK);
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
